// File: rtl/duty_ctrl_pkg.sv
// Shared definitions for the duty-adjust button front end: channel FSM states,
// default timing constants and counter-width helpers.
package duty_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2,
    ST_LOCKED = 2'd3
  } btn_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1024;
  localparam int unsigned DEF_HOLD_CYCLES     = 50000;
  localparam int unsigned DEF_REPEAT_CYCLES   = 20000;

  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer; the level flips
// only after DEBOUNCE_CYCLES consecutive synced samples disagree with it.
module button_debounce
  import duty_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_level_next
);

  localparam int unsigned     CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;

  always_comb begin
    sync_d  = {sync_q[0], i_btn};
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign o_level      = level_q;
  assign o_level_next = level_d;

endmodule

// File: rtl/duty_button_ctrl.sv
// Debounced up/down buttons with press/hold/auto-repeat strobes; holding both
// buttons locks both channels out until each is released.
module duty_button_ctrl
  import duty_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_up,
  input  logic i_btn_down,
  output logic o_inc_pulse,
  output logic o_dec_pulse,
  output logic o_up_level,
  output logic o_down_level,
  output logic o_repeat_active
);

  localparam int unsigned   TW          = max_u(cnt_width(HOLD_CYCLES), cnt_width(REPEAT_CYCLES));
  localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_CYCLES - 1);

  logic [1:0] lvl_q;
  logic [1:0] lvl_nx;
  logic [1:0] pulse_vec;
  logic [1:0] rep_nx;
  logic       repeat_q;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_btn        (i_btn_up),
    .o_level      (lvl_q[0]),
    .o_level_next (lvl_nx[0])
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_btn        (i_btn_down),
    .o_level      (lvl_q[1]),
    .o_level_next (lvl_nx[1])
  );

  // Channel 0 drives increase, channel 1 decrease. Decisions use the levels
  // being registered on this edge so a strobe lands on the level-rise edge.
  for (genvar c = 0; c < 2; c++) begin : g_ch
    localparam int unsigned OTHER = 1 - c;

    btn_state_e    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          pulse_q, pulse_d;
    logic          own, other;

    assign own   = lvl_nx[c];
    assign other = lvl_nx[OTHER];

    always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      pulse_d = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          timer_d = '0;
          if (own) begin
            if (other) begin
              state_d = ST_LOCKED;
            end else begin
              state_d = ST_HOLD;
              pulse_d = 1'b1;
            end
          end
        end
        ST_HOLD, ST_REPEAT: begin
          if (!own) begin
            state_d = ST_IDLE;
            timer_d = '0;
          end else if (other) begin
            state_d = ST_LOCKED;
            timer_d = '0;
          end else if (timer_q == ((state_q == ST_HOLD) ? HOLD_LAST : REPEAT_LAST)) begin
            state_d = ST_REPEAT;
            timer_d = '0;
            pulse_d = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_LOCKED: begin
          timer_d = '0;
          if (!own) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          timer_d = '0;
        end
      endcase
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        state_q <= ST_IDLE;
        timer_q <= '0;
        pulse_q <= 1'b0;
      end else begin
        state_q <= state_d;
        timer_q <= timer_d;
        pulse_q <= pulse_d;
      end
    end

    assign pulse_vec[c] = pulse_q;
    assign rep_nx[c]    = (state_d == ST_REPEAT);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      repeat_q <= 1'b0;
    end else begin
      repeat_q <= |rep_nx;
    end
  end

  assign o_inc_pulse     = pulse_vec[0];
  assign o_dec_pulse     = pulse_vec[1];
  assign o_up_level      = lvl_q[0];
  assign o_down_level    = lvl_q[1];
  assign o_repeat_active = repeat_q;

endmodule

// File: tb/tb_duty_button_ctrl.sv
// Directed bench for duty_button_ctrl with an edge-level behavioural model of
// press/hold/repeat timing and literal strobe-edge expectations per scenario.
module tb_duty_button_ctrl;

  localparam int DB = 4;
  localparam int H  = 20;
  localparam int R  = 8;

  logic clk;
  logic i_rst, i_btn_up, i_btn_down;
  logic o_inc_pulse, o_dec_pulse, o_up_level, o_down_level, o_repeat_active;

  duty_button_ctrl #(
    .DEBOUNCE_CYCLES (DB),
    .HOLD_CYCLES     (H),
    .REPEAT_CYCLES   (R)
  ) dut (
    .i_clk           (clk),
    .i_rst           (i_rst),
    .i_btn_up        (i_btn_up),
    .i_btn_down      (i_btn_down),
    .o_inc_pulse     (o_inc_pulse),
    .o_dec_pulse     (o_dec_pulse),
    .o_up_level      (o_up_level),
    .o_down_level    (o_down_level),
    .o_repeat_active (o_repeat_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic chk_log(input string nm, input int act[$], input int exp[$]);
    chk({nm, "_count"}, act.size(), exp.size());
    for (int i = 0; i < act.size() && i < exp.size(); i++)
      chk($sformatf("%s_edge%0d", nm, i), act[i], exp[i]);
  endtask

  // Behavioural model, advanced on every rising edge
  int  edge_n = 0;
  int  base   = 0;
  bit  dl  [2][2];
  bit  win [2][DB];
  int  nwin[2];
  bit  mL  [2];
  int  mode[2];   // 0 released, 1 pressed and owning output, 2 locked out
  int  t0  [2];
  bit  mP  [2];
  bit  mRep;

  always @(posedge clk) begin
    bit raw[2];
    bit s, all;
    int d;
    edge_n++;
    raw[0] = i_btn_up;
    raw[1] = i_btn_down;
    if (i_rst) begin
      for (int c = 0; c < 2; c++) begin
        dl[c][0] = 0; dl[c][1] = 0; nwin[c] = 0;
        mL[c] = 0; mode[c] = 0; mP[c] = 0;
      end
      mRep = 0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        s = dl[c][0];
        dl[c][0] = dl[c][1];
        dl[c][1] = raw[c];
        for (int i = 0; i < DB - 1; i++) win[c][i] = win[c][i+1];
        win[c][DB-1] = s;
        if (nwin[c] < DB) nwin[c]++;
        all = (nwin[c] == DB);
        for (int i = 0; i < DB; i++) if (win[c][i] == mL[c]) all = 0;
        if (all) mL[c] = !mL[c];
      end
      mRep = 0;
      for (int c = 0; c < 2; c++) begin
        case (mode[c])
          0: if (mL[c]) begin
               if (mL[1-c]) mode[c] = 2;
               else begin mode[c] = 1; t0[c] = edge_n; end
             end
          1: if (!mL[c]) mode[c] = 0;
             else if (mL[1-c]) mode[c] = 2;
          default: if (!mL[c]) mode[c] = 0;
        endcase
        d = edge_n - t0[c];
        mP[c] = (mode[c] == 1) && (d == 0 || (d >= H && (d - H) % R == 0));
        if (mode[c] == 1 && d >= H) mRep = 1;
      end
    end
  end

  // Per-cycle comparison and event logging
  bit chk_on = 0;
  int inc_log[$];
  int dec_log[$];
  int up_rise, rep_first, rep_last;
  bit dn_seen, up_seen;

  always @(negedge clk) begin
    int rel;
    if (chk_on) begin
      rel = edge_n - base;
      chk("up_level",   o_up_level,      mL[0]);
      chk("down_level", o_down_level,    mL[1]);
      chk("inc_pulse",  o_inc_pulse,     mP[0]);
      chk("dec_pulse",  o_dec_pulse,     mP[1]);
      chk("repeat_act", o_repeat_active, mRep);
      chk("pulse_excl", o_inc_pulse & o_dec_pulse, 0);
      if (o_inc_pulse) inc_log.push_back(rel);
      if (o_dec_pulse) dec_log.push_back(rel);
      if (o_up_level) begin
        up_seen = 1;
        if (up_rise < 0) up_rise = rel;
      end
      if (o_down_level) dn_seen = 1;
      if (o_repeat_active) begin
        if (rep_first < 0) rep_first = rel;
        rep_last = rel;
      end
    end
  end

  task automatic mark();
    base = edge_n;
    inc_log.delete();
    dec_log.delete();
    up_rise = -1; rep_first = -1; rep_last = -1;
    dn_seen = 0; up_seen = 0;
  endtask

  task automatic run_to(input int n);
    while (edge_n - base < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    i_btn_up = 0;
    i_btn_down = 0;
    i_rst = 1;
    @(posedge clk);
    #1;
    i_rst = 0;
    mark();
  endtask

  int exp_q[$];

  initial begin
    i_rst = 1; i_btn_up = 0; i_btn_down = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_up_level",  o_up_level,      0);
    chk("reset_inc",       o_inc_pulse,     0);
    chk("reset_repeat",    o_repeat_active, 0);
    chk_on = 1;

    // Idle after reset
    do_reset();
    run_to(100);
    chk("idle_activity", inc_log.size() + dec_log.size() + int'(up_seen) + int'(dn_seen), 0);
    chk("idle_repeat", rep_first, -1);

    // Single short press
    do_reset();
    run_to(10); i_btn_up = 1;
    run_to(25); i_btn_up = 0;
    run_to(50);
    exp_q = '{16};
    chk_log("single_inc", inc_log, exp_q);
    chk("single_dec_count", dec_log.size(), 0);
    chk("single_up_rise", up_rise, 16);

    // Bouncing down button
    do_reset();
    for (int i = 0; i < 15; i++) begin
      run_to(10 + 2 * i);
      i_btn_down = (i % 2 == 0);
    end
    run_to(40); i_btn_down = 0;
    run_to(70);
    chk("bounce_down_seen", dn_seen, 0);
    chk("bounce_strobes", inc_log.size() + dec_log.size(), 0);

    // Hold into auto-repeat
    do_reset();
    run_to(10); i_btn_up = 1;
    run_to(70); i_btn_up = 0;
    run_to(100);
    exp_q = '{16, 36, 44, 52, 60, 68};
    chk_log("repeat_inc", inc_log, exp_q);
    chk("repeat_first", rep_first, 36);
    chk("repeat_last",  rep_last,  75);

    // Conflict: both held locks out, then down alone strobes once
    do_reset();
    run_to(10); i_btn_up = 1;
    run_to(25); i_btn_down = 1;
    run_to(45); i_btn_up = 0; i_btn_down = 0;
    run_to(60); i_btn_down = 1;
    run_to(70); i_btn_down = 0;
    run_to(100);
    exp_q = '{16};
    chk_log("conflict_inc", inc_log, exp_q);
    exp_q = '{66};
    chk_log("conflict_dec", dec_log, exp_q);

    // Reset during repeat with button still held
    do_reset();
    run_to(10); i_btn_up = 1;
    run_to(40); i_rst = 1;
    run_to(41);
    chk("midrst_up_level", o_up_level,      0);
    chk("midrst_repeat",   o_repeat_active, 0);
    chk("midrst_inc",      o_inc_pulse,     0);
    i_rst = 0;
    run_to(50); i_btn_up = 0;
    run_to(80);
    exp_q = '{16, 36, 47};
    chk_log("midrst_inc_log", inc_log, exp_q);
    chk("midrst_rep_first", rep_first, 36);

    chk_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
